// File: rtl/adder_digit_serial.sv
// Digit-serial ripple adder: {cout,sum} = a + b + cin, DIGIT bits per clock, LSB digit first,
// one carry register between digits; the low APPROX_LSB bits may use lower-part-OR approximation.
module adder_digit_serial #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int APPROX_LSB = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LASTCNT = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic [IW-1:0]    base, idx;
    logic [DIGIT-1:0] dsum;
    logic             dcarry, abit, bbit;

    initial begin
        if (WIDTH % DIGIT != 0) $error("WIDTH must be a multiple of DIGIT");
        if (APPROX_LSB > WIDTH) $error("APPROX_LSB must not exceed WIDTH");
    end

    // A new operation may start while the previous result is being handed off.
    assign in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign last      = (cnt == LASTCNT);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE: begin
                if (accept)         next_state = RUN;
                else if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // One digit per cycle; approximate bits OR their operands and only the top one feeds a carry upward.
    always_comb begin
        base   = IW'(int'(cnt) * DIGIT);
        idx    = '0;
        abit   = 1'b0;
        bbit   = 1'b0;
        dsum   = '0;
        dcarry = carry;
        for (int j = 0; j < DIGIT; j++) begin
            idx  = base + IW'(j);
            abit = opa[idx];
            bbit = opb[idx];
            if (int'(idx) < APPROX_LSB) begin
                dsum[j] = abit | bbit;
                dcarry  = (int'(idx) == APPROX_LSB - 1) & abit & bbit;
            end else begin
                dsum[j] = abit ^ bbit ^ dcarry;
                dcarry  = (abit & bbit) | (dcarry & (abit ^ bbit));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= (APPROX_LSB == 0) ? cin : 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum[base +: DIGIT] <= dsum;
            carry <= dcarry;
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) cout <= dcarry;
        end
    end
endmodule

// File: tb/tb_adder_digit_serial.sv
// Bench for adder_digit_serial: directed vectors, backpressure and reset cases on a 16/4 exact instance,
// plus five more configurations each running directed vectors and a random scoreboard stream.
module tb_adder_digit_serial;
    logic        clk;
    logic        rst0, rstg;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;

    int total = 0;
    int bad = 0;
    int done_count = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        int          cfg;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } dir_t;

    vec_t vecs[6];
    dir_t dirv[11];

    localparam logic [4:0][7:0] CFGW = {8'd8, 8'd12, 8'd16, 8'd16, 8'd16};
    localparam logic [4:0][7:0] CFGD = {8'd8, 8'd3,  8'd4,  8'd16, 8'd1};
    localparam logic [4:0][7:0] CFGL = {8'd8, 8'd5,  8'd4,  8'd0,  8'd0};
    localparam int NOPS  = 500;
    localparam int LIMIT = 40000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    adder_digit_serial #(.WIDTH(16), .DIGIT(4), .APPROX_LSB(0)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Presents one operation, waits for the handshake, then counts cycles until out_valid.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic ci, output int lat);
        int c;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
        #1;
        c = 0;
        while (!in_ready && c < 50) begin
            @(negedge clk); #1; c++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk); #1; lat++;
        end
    endtask

    for (genvar g = 0; g < 5; g++) begin : g_cfg
        localparam int W    = int'(CFGW[g]);
        localparam int D    = int'(CFGD[g]);
        localparam int L    = int'(CFGL[g]);
        localparam int NDIG = W / D;
        localparam int LM1  = (L > 0) ? L - 1 : 0;

        logic         gv, gin_ready, gcin, gout_valid, gor, gcout;
        logic [W-1:0] ga, gb, gsum;
        logic [W:0]   q[$];

        adder_digit_serial #(.WIDTH(W), .DIGIT(D), .APPROX_LSB(L)) dut (
            .clk(clk), .rst(rstg), .in_valid(gv), .in_ready(gin_ready),
            .a(ga), .b(gb), .cin(gcin), .out_valid(gout_valid), .out_ready(gor),
            .sum(gsum), .cout(gcout)
        );

        // Reference: exact add, or OR over the low L bits with a[L-1]&b[L-1] carried into the upper add.
        function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
            longint unsigned xa, ya, hi, r;
            xa = 64'(x);
            ya = 64'(y);
            if (L == 0) begin
                r = xa + ya + 64'(ci);
            end else begin
                hi = (xa >> L) + (ya >> L) + ((xa >> LM1) & (ya >> LM1) & 64'd1);
                r  = (hi << L) | ((xa | ya) & ((64'd1 << L) - 64'd1));
            end
            return r[W:0];
        endfunction

        task automatic dirOp(input int i);
            int c;
            gv = 1'b1;
            ga = W'(dirv[i].a);
            gb = W'(dirv[i].b);
            gcin = dirv[i].cin;
            gor = 1'b1;
            #1;
            c = 0;
            while (!gin_ready && c < 50) begin
                @(negedge clk); #1; c++;
            end
            @(negedge clk);
            gv = 1'b0;
            #1;
            c = 0;
            while (!gout_valid && c < 200) begin
                @(negedge clk); #1; c++;
            end
            checkOutput($sformatf("cfg%0d dir%0d latency", g, i), 32'(c), 32'(NDIG));
            checkOutput($sformatf("cfg%0d dir%0d result", g, i), 32'({gcout, gsum}),
                        32'({dirv[i].cout, W'(dirv[i].sum)}));
        endtask

        initial begin
            int         cyc, sent, got;
            logic       acc_next;
            logic [W:0] expv;
            gv = 1'b0; gor = 1'b1; ga = '0; gb = '0; gcin = 1'b0;
            wait (rstg == 1'b0);
            @(negedge clk); #1;
            for (int i = 0; i < 11; i++)
                if (dirv[i].cfg == g) dirOp(i);

            cyc = 0; sent = 0; got = 0; acc_next = 1'b0;
            while ((sent < NOPS || q.size() != 0) && cyc < LIMIT) begin
                @(negedge clk);
                cyc++;
                if (gv && acc_next) gv = 1'b0;
                if (!gv && sent < NOPS && $urandom_range(0, 3) != 0) begin
                    gv = 1'b1;
                    ga = W'($urandom);
                    gb = W'($urandom);
                    gcin = 1'($urandom);
                end
                gor = ($urandom_range(0, 3) != 0);
                #1;
                if (gout_valid && gor) begin
                    checkOutput($sformatf("cfg%0d result pending", g), 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        expv = q.pop_front();
                        checkOutput($sformatf("cfg%0d random op%0d", g, got), 32'({gcout, gsum}), 32'(expv));
                    end
                    got++;
                end
                acc_next = gv && gin_ready;
                if (acc_next) begin
                    q.push_back(model(ga, gb, gcin));
                    sent++;
                end
            end
            gv = 1'b0;
            gor = 1'b1;
            checkOutput($sformatf("cfg%0d results received", g), 32'(got), 32'(NOPS));
            checkOutput($sformatf("cfg%0d queue drained", g), 32'(q.size()), 32'd0);
            done_count++;
        end
    end

    initial begin
        int lat;
        int c;
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        vecs[2] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};

        dirv[0]  = '{0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        dirv[1]  = '{0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        dirv[2]  = '{1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        dirv[3]  = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        dirv[4]  = '{2, 16'h000F, 16'h0001, 1'b1, 16'h000F, 1'b0};
        dirv[5]  = '{2, 16'h0008, 16'h0008, 1'b0, 16'h0018, 1'b0};
        dirv[6]  = '{2, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 1'b0};
        dirv[7]  = '{3, 16'h001F, 16'h0010, 1'b1, 16'h003F, 1'b0};
        dirv[8]  = '{3, 16'h0FFF, 16'h0FFF, 1'b0, 16'h0FFF, 1'b1};
        dirv[9]  = '{4, 16'h0080, 16'h0080, 1'b0, 16'h0080, 1'b1};
        dirv[10] = '{4, 16'h000F, 16'h00F0, 1'b1, 16'h00FF, 1'b0};

        rst0 = 1'b1; rstg = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset state", 32'({in_ready, out_valid, cout, sum}), 32'd0);
        @(negedge clk);
        rst0 = 1'b0; rstg = 1'b0;
        #1;
        checkOutput("ready after reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            checkOutput($sformatf("vec%0d result", i), 32'({cout, sum}), 32'({vecs[i].cout, vecs[i].sum}));
        end
        @(negedge clk); #1;

        // Result held under backpressure while a new operand is waiting and must be ignored.
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h1111, 1'b0, lat);
        checkOutput("bp latency", 32'(lat), 32'd4);
        in_valid = 1'b1; a = 16'd3; b = 16'd5; cin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("bp hold %0d", i), 32'({out_valid, in_ready, cout, sum}),
                        32'({1'b1, 1'b0, 1'b0, 16'h2345}));
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("bp retire", 32'(out_valid), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk); #1; lat++;
        end
        checkOutput("bp overlap latency", 32'(lat), 32'd4);
        checkOutput("bp next result", 32'({cout, sum}), 32'd8);

        // Reset two digits into an operation.
        @(negedge clk); #1;
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        #1;
        checkOutput("reset mid-run", 32'({in_ready, out_valid, cout, sum}), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        checkOutput("ready after mid-run reset", 32'(in_ready), 32'd1);
        applyStimulus(16'd1, 16'd1, 1'b0, lat);
        checkOutput("post-reset latency", 32'(lat), 32'd4);
        checkOutput("post-reset result", 32'({cout, sum}), 32'd2);
        @(negedge clk);

        c = 0;
        while (done_count < 5 && c < 60000) begin
            @(negedge clk); c++;
        end
        checkOutput("all configs finished", 32'(done_count), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
